alarm_set_controller: RTL
=========================

// Module: alarm_set_controller
// PURPOSE
//  Sequences keypad entry of a new HH:MM value for the alarm clock. Sits between the
//  user inputs (alarm_button, time_button, keypad_buttons) and the timekeeping datapath.
//  Collects four decimal digits, validates them as a 24-hour time, then issues a
//  one-cycle load strobe to either the current-time counter or the alarm register.
// PARAMETERS
//  TIMEOUT_CYCLES   153600  idle cycles with no key press before entry aborts
//  CNT_W            18      width of timeout/debounce counter; must hold TIMEOUT_CYCLES
//  DEBOUNCE_CYCLES  1024    stable cycles a key/release needs (KEY_DEBOUNCE_EN only)
// PORTS
//  clk             in   1   system clock, rising edge
//  reset           in   1   asynchronous, active-low reset
//  alarm_button    in   1   level; rising edge starts alarm entry
//  time_button     in   1   level; rising edge starts time entry
//  keypad_buttons  in   10  level; bit k high = digit k held
//  entry_active    out  1   high while collecting digits
//  entry_target    out  1   0 = time, 1 = alarm; valid while entry_active or load pulse
//  digit_count     out  3   digits accepted so far, 0..4
//  set_hour        out  5   validated hour 0..23, held until next commit
//  set_min         out  6   validated minute 0..59, held until next commit
//  load_time       out  1   one-cycle strobe: datapath loads set_hour/set_min as time
//  load_alarm      out  1   one-cycle strobe: datapath loads set_hour/set_min as alarm
//  entry_error     out  1   one-cycle strobe: entry rejected (invalid value)
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE; all outputs 0; digit buffer, edge and
//    debounce registers and timeout counter cleared. Takes effect mid-entry; no strobe.
//  - Inputs registered once; button press = registered rising edge (0->1).
//  - Key press event: registered keypad is exactly one-hot while the previous sample
//    was all-zero. Multi-bit patterns are ignored and do not rearm. Keys are ignored
//    outside ENTER.
//  - FSM states: IDLE, ENTER, VALIDATE, COMMIT.
//   IDLE: time press -> ENTER, target=0; alarm press -> ENTER, target=1. Same-cycle
//     presses of both: time wins. Entering ENTER sets digit_count=0, timer=0.
//   ENTER: each key event stores a digit in order H-tens, H-units, M-tens, M-units.
//     It increments digit_count and clears the timer. The event that makes
//     digit_count=4 moves to VALIDATE. A button press aborts to IDLE with no strobe.
//     Timer reaching TIMEOUT_CYCLES-1 without a key aborts to IDLE with no strobe.
//   VALIDATE (1 cycle): valid iff hour = 10*Ht+Hu <= 23 and minute = 10*Mt+Mu <= 59.
//     Valid -> COMMIT with set_hour/set_min updated. Invalid -> entry_error=1 for one
//     cycle -> IDLE; set_hour/set_min unchanged.
//   COMMIT (1 cycle): load_time or load_alarm = 1 per target -> IDLE.
//  - Latency: strobe is high exactly 2 cycles after the 4th key press event cycle.
//  - Arithmetic: hour/minute built as tens*10+units in 7 bits, then truncated to 5/6.
//  - load_time, load_alarm and entry_error are mutually exclusive, never high >1 cycle.
//  - entry_active = (state==ENTER); digit_count returns to 0 on entering IDLE.
// CONFIGURATION
//  KEY_DEBOUNCE_EN defined:
//  - A key pattern must hold unchanged for DEBOUNCE_CYCLES before a press event.
//  - Rearm needs all-zero stable for DEBOUNCE_CYCLES. Buttons debounced likewise.
//  KEY_DEBOUNCE_EN undefined:
//  - Single registered sample, no debounce logic, DEBOUNCE_CYCLES unused.
//  (All TESTING latencies assume undefined. With it defined, add DEBOUNCE_CYCLES.)
// TESTING
//  1. Reset low mid-run -> all outputs 0 immediately. Release, idle 100 cycles -> no strobes.
//  2. time_button, keys 0,4,3,5 -> load_time 1 cycle, 2 cycles after last key;
//     set_hour=4, set_min=35; load_alarm=0.
//  3. alarm_button, keys 0,7,1,4 -> load_alarm pulse, set_hour=7, set_min=14;
//     entry_target=1.
//  4. time_button, keys 2,5,0,0 -> entry_error pulse, no load; set_hour/min keep
//     prior 7/14.
//  5. time_button, key 1, keys {3,4} together, then silence TIMEOUT_CYCLES ->
//     digit_count stays 1, entry_active drops, no strobe.
//  6. time_button, keys 1,2, reset pulse low, then time_button, 2,3,5,9 ->
//     load_time with 23/59; both buttons same cycle in IDLE -> target=0.

Source files
------------

// File: rtl/alarm_set_controller.sv
// Keypad HH:MM entry sequencer: collects four digits, validates a 24-hour time, strobes a load.
// Optional input debounce is enabled with the KEY_DEBOUNCE_EN macro.
module alarm_set_controller #(
  parameter int TIMEOUT_CYCLES  = 153600,
  parameter int CNT_W           = 18,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarm_button,
  input  logic       time_button,
  input  logic [9:0] keypad_buttons,
  output logic       entry_active,
  output logic       entry_target,
  output logic [2:0] digit_count,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic       load_time,
  output logic       load_alarm,
  output logic       entry_error
);

  typedef enum logic [1:0] {IDLE, ENTER, VALIDATE, COMMIT} state_t;

  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << CNT_W) ||
      DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_W)) begin : g_bad_params
    $error("alarm_set_controller: CNT_W too narrow for TIMEOUT_CYCLES/DEBOUNCE_CYCLES");
  end

  // Bit layout of sampled inputs: {alarm, time, keypad[9:0]}
  logic [11:0] raw_q;
  logic [11:0] samp;
  logic [11:0] samp_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_q <= '0;
    end else begin
      raw_q <= {alarm_button, time_button, keypad_buttons};
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [11:0]      raw_prev;
  logic [CNT_W-1:0] deb_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_prev <= '0;
      deb_cnt  <= '0;
      samp     <= '0;
    end else begin
      raw_prev <= raw_q;
      if (raw_q != raw_prev) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_MAX) begin
        samp <= raw_q;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end
`else
  assign samp = raw_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_prev <= '0;
    end else begin
      samp_prev <= samp;
    end
  end

  logic       time_press;
  logic       alarm_press;
  logic       key_evt;
  logic [3:0] key_digit;

  assign time_press  = samp[10] & ~samp_prev[10];
  assign alarm_press = samp[11] & ~samp_prev[11];
  // A multi-key pattern leaves samp_prev non-zero, so it also blocks rearming
  assign key_evt     = $onehot(samp[9:0]) && (samp_prev[9:0] == 10'd0);

  always_comb begin
    key_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (samp[i]) key_digit = 4'(i);
    end
  end

  state_t           state, state_n;
  logic             target, target_n;
  logic [2:0]       count_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [3:0][3:0]  dig, dig_n;
  logic [4:0]       hour_n;
  logic [5:0]       min_n;
  logic [6:0]       hour_sum;
  logic [6:0]       min_sum;
  logic             valid;

  assign hour_sum = 7'(dig[0]) * 7'd10 + 7'(dig[1]);
  assign min_sum  = 7'(dig[2]) * 7'd10 + 7'(dig[3]);
  assign valid    = (hour_sum <= 7'd23) && (min_sum <= 7'd59);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      target      <= 1'b0;
      digit_count <= '0;
      timer       <= '0;
      dig         <= '0;
      set_hour    <= '0;
      set_min     <= '0;
    end else begin
      state       <= state_n;
      target      <= target_n;
      digit_count <= count_n;
      timer       <= timer_n;
      dig         <= dig_n;
      set_hour    <= hour_n;
      set_min     <= min_n;
    end
  end

  always_comb begin
    state_n  = state;
    target_n = target;
    count_n  = digit_count;
    timer_n  = timer;
    dig_n    = dig;
    hour_n   = set_hour;
    min_n    = set_min;
    case (state)
      IDLE: begin
        count_n = 3'd0;
        timer_n = '0;
        if (time_press) begin
          state_n  = ENTER;
          target_n = 1'b0;
        end else if (alarm_press) begin
          state_n  = ENTER;
          target_n = 1'b1;
        end
      end
      ENTER: begin
        if (time_press || alarm_press) begin
          state_n = IDLE;
          count_n = 3'd0;
        end else if (key_evt) begin
          dig_n[digit_count[1:0]] = key_digit;
          count_n = digit_count + 3'd1;
          timer_n = '0;
          if (digit_count == 3'd3) state_n = VALIDATE;
        end else if (timer == TMAX) begin
          state_n = IDLE;
          count_n = 3'd0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      VALIDATE: begin
        if (valid) begin
          state_n = COMMIT;
          hour_n  = hour_sum[4:0];
          min_n   = min_sum[5:0];
        end else begin
          state_n = IDLE;
          count_n = 3'd0;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = 3'd0;
      end
    endcase
  end

  assign entry_active = (state == ENTER);
  assign entry_target = target;
  assign load_time    = (state == COMMIT) && !target;
  assign load_alarm   = (state == COMMIT) && target;
  assign entry_error  = (state == VALIDATE) && !valid;

endmodule
